// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================
// Package : i2s_pkg
// Shared FSM encoding, sizing constants and slot-length helper.
// Rev     : 1.0
// ============================================================
package i2s_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int CNT_MAX       = 63;
  localparam int CNT_W         = 6;

  typedef enum logic [1:0] {
    ST_SYNC       = 2'd0,
    ST_CAP_L_WAIT = 2'd1,
    ST_CAP_R      = 2'd2
  } state_e;

  // A slot is the right length when the counter has seen exactly width-1
  // bits before the edge that samples its LSB.
  function automatic logic slot_len_ok(input logic [CNT_W-1:0] cnt, input int width);
    return cnt == CNT_W'(width - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_ws_edge.sv
`default_nettype none
// ============================================================
// Module : i2s_ws_edge
// Delays ws by one sck and flags slot boundaries with their channel.
// Rev    : 1.0
// ============================================================
module i2s_ws_edge (
  input  logic sck,
  input  logic rst,
  input  logic i_ws,
  output logic o_ws_event,
  output logic o_channel
);

  logic ws_d1_q;
  logic ws_d1_d;

  always_comb begin
    ws_d1_d = i_ws;
  end

  always_ff @(posedge sck or negedge rst) begin
    if (!rst) begin
      ws_d1_q <= 1'b0;
    end else begin
      ws_d1_q <= ws_d1_d;
    end
  end

  // The slot that ends on an event belongs to the previous ws level.
  assign o_ws_event = i_ws ^ ws_d1_q;
  assign o_channel  = ws_d1_q;

endmodule
`default_nettype wire

// File: rtl/i2s_stereo_deserializer.sv
`default_nettype none
// ============================================================
// Module : i2s_stereo_deserializer
// Standard I2S receiver delivering left/right pairs over valid/ready.
// Rev    : 1.0
// ============================================================
module i2s_stereo_deserializer
  import i2s_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             sck,
  input  logic             rst,
  input  logic             ws,
  input  logic             sd,
  output logic [WIDTH-1:0] out_left,
  output logic [WIDTH-1:0] out_right,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             frame_err
);

  logic             ws_event;
  logic             channel;
  logic [WIDTH-1:0] word;
  logic             slot_good;
  logic             pair_done;
  logic             bad_slot;

  // The live sd bit is the LSB of the WIDTH-bit window, so only the
  // older WIDTH-1 bits need storage.
  logic [WIDTH-2:0] shift_q,     shift_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  state_e           state_q,     state_d;
  logic [WIDTH-1:0] left_q,      left_d;
  logic [WIDTH-1:0] out_left_q,  out_left_d;
  logic [WIDTH-1:0] out_right_q, out_right_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q,   overrun_d;
  logic             frame_err_q, frame_err_d;

  i2s_ws_edge u_ws_edge (
    .sck        (sck),
    .rst        (rst),
    .i_ws       (ws),
    .o_ws_event (ws_event),
    .o_channel  (channel)
  );

  assign word      = {shift_q, sd};
  assign slot_good = slot_len_ok(cnt_q, WIDTH);

  always_comb begin
    shift_d = {shift_q[WIDTH-3:0], sd};
    if (ws_event) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(CNT_MAX)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    left_d    = left_q;
    pair_done = 1'b0;
    bad_slot  = 1'b0;
    if (ws_event) begin
      unique case (state_q)
        ST_SYNC: begin
          state_d = ST_CAP_L_WAIT;
        end
        ST_CAP_L_WAIT: begin
          if (!slot_good) begin
            bad_slot = 1'b1;
          end else if (!channel) begin
            left_d  = word;
            state_d = ST_CAP_R;
          end
        end
        ST_CAP_R: begin
          state_d = ST_CAP_L_WAIT;
          if (!slot_good) begin
            bad_slot = 1'b1;
          end else if (channel) begin
            pair_done = 1'b1;
          end
        end
        default: begin
          state_d = ST_SYNC;
        end
      endcase
    end
  end

  // A finished pair may replace the held one only if it leaves this edge.
  always_comb begin
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q | bad_slot;
    if (pair_done) begin
      if (!out_valid_q || out_ready) begin
        out_left_d  = left_q;
        out_right_d = word;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge sck or negedge rst) begin
    if (!rst) begin
      shift_q     <= '0;
      cnt_q       <= '0;
      state_q     <= ST_SYNC;
      left_q      <= '0;
      out_left_q  <= '0;
      out_right_q <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      left_q      <= left_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_left  = out_left_q;
  assign out_right = out_right_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_stereo_deserializer.sv
`default_nettype none
// ============================================================
// Module : tb_i2s_stereo_deserializer
// Directed and randomized I2S streams checked against a slot-level model.
// Rev    : 1.0
// ============================================================
module tb_i2s_stereo_deserializer;

  localparam int W = 16;

  logic         sck = 1'b0;
  logic         rst = 1'b0;
  logic         ws = 1'b0;
  logic         sd = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_left;
  logic [W-1:0] out_right;
  logic         out_valid;
  logic         overrun;
  logic         frame_err;

  int n_checks = 0;
  int n_errors = 0;

  logic rst_req = 1'b0;
  logic rdy_req = 1'b0;
  logic rnd_rdy = 1'b0;
  logic cmp_en  = 1'b0;

  // Pairs actually accepted from the DUT
  int           acc_cnt = 0;
  logic [W-1:0] acc_l = '0;
  logic [W-1:0] acc_r = '0;

  // Slot-level model state
  logic         m_ws = 1'b0;
  logic         m_synced = 1'b0;
  logic         m_have_left = 1'b0;
  logic [W-1:0] m_left = '0;
  logic [W-1:0] m_l = '0;
  logic [W-1:0] m_r = '0;
  logic         m_v = 1'b0;
  logic         m_ovr = 1'b0;
  logic         m_ferr = 1'b0;
  bit           m_bits[$];

  always #5 sck = ~sck;

  i2s_stereo_deserializer #(.WIDTH(W)) dut (
    .sck       (sck),
    .rst       (rst),
    .ws        (ws),
    .sd        (sd),
    .out_left  (out_left),
    .out_right (out_right),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ws = 1'b0; m_synced = 1'b0; m_have_left = 1'b0; m_left = '0;
    m_l = '0; m_r = '0; m_v = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    m_bits.delete();
  endtask

  // Advances the model by one sck rising edge using the inputs now applied.
  task automatic model_step();
    logic         ev;
    logic         ch;
    logic         good;
    logic         done;
    logic [W-1:0] word;
    ev = (ws != m_ws);
    ch = m_ws;
    m_ws = ws;
    m_bits.push_back(sd);
    if (m_bits.size() > 64) void'(m_bits.pop_front());
    done = 1'b0;
    word = '0;
    if (ev) begin
      good = (m_bits.size() == W);
      foreach (m_bits[i]) word = {word[W-2:0], m_bits[i]};
      m_bits.delete();
      if (!m_synced) begin
        m_synced = 1'b1;
      end else if (!good) begin
        m_ferr = 1'b1;
        m_have_left = 1'b0;
      end else if (!ch && !m_have_left) begin
        m_left = word;
        m_have_left = 1'b1;
      end else if (ch && m_have_left) begin
        done = 1'b1;
        m_have_left = 1'b0;
      end
    end
    if (done) begin
      if (!m_v || out_ready) begin
        m_l = m_left;
        m_r = word;
        m_v = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_v && out_ready) begin
      m_v = 1'b0;
    end
  endtask

  task automatic cmp_all();
    if (cmp_en) begin
      check("out_valid", out_valid, m_v);
      check("out_left", out_left, m_l);
      check("out_right", out_right, m_r);
      check("overrun", overrun, m_ovr);
      check("frame_err", frame_err, m_ferr);
    end
  endtask

  // One sck period: compare, drive inputs at the falling edge, step the model.
  task automatic send_bit(input logic w, input logic d);
    @(negedge sck);
    cmp_all();
    ws  = w;
    sd  = d;
    rst = rst_req;
    out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_req;
    if (rst) begin
      if (out_valid && out_ready) begin
        acc_cnt++;
        acc_l = out_left;
        acc_r = out_right;
      end
      model_step();
    end else begin
      model_reset();
    end
  endtask

  task automatic send_slot(input logic ch, input logic [31:0] word, input int len);
    for (int i = len - 1; i >= 0; i--) send_bit((i == 0) ? ~ch : ch, word[i]);
  endtask

  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r);
    send_slot(1'b0, 32'(l), W);
    send_slot(1'b1, 32'(r), W);
  endtask

  task automatic idle(input int n);
    repeat (n) send_bit(ws, 1'b0);
  endtask

  task automatic do_reset();
    rst_req = 1'b0;
    rdy_req = 1'b0;
    repeat (3) send_bit(1'b0, 1'b0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_left", out_left, 0);
    check("rst_out_right", out_right, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_err", frame_err, 0);
    rst_req = 1'b1;
  endtask

  initial begin
    int a0;
    int sel;
    repeat (2) @(negedge sck);
    cmp_en = 1'b1;

    // Three clean frames, consumer always ready
    do_reset();
    rdy_req = 1'b1;
    a0 = acc_cnt;
    repeat (3) send_frame(16'hA5C3, 16'h1234);
    idle(3);
    check("s1_pairs", acc_cnt - a0, 2);
    check("s1_left", acc_l, 16'hA5C3);
    check("s1_right", acc_r, 16'h1234);
    check("s1_overrun", overrun, 0);
    check("s1_frame_err", frame_err, 0);

    // Back-pressure: first pair held, second dropped
    do_reset();
    send_frame(16'h1111, 16'h2222);
    send_frame(16'h1111, 16'h2222);
    send_frame(16'h3333, 16'h4444);
    idle(2);
    check("s2_overrun", overrun, 1);
    check("s2_valid_held", out_valid, 1);
    check("s2_left_held", out_left, 16'h1111);
    a0 = acc_cnt;
    rdy_req = 1'b1;
    idle(4);
    check("s2_pairs", acc_cnt - a0, 1);
    check("s2_acc_left", acc_l, 16'h1111);
    check("s2_acc_right", acc_r, 16'h2222);
    check("s2_valid_clear", out_valid, 0);

    // Short left slot
    do_reset();
    rdy_req = 1'b1;
    send_frame(16'h0000, 16'h0000);
    a0 = acc_cnt;
    send_slot(1'b0, 32'h7E01, W - 1);
    send_slot(1'b1, 32'h5A5A, W);
    check("s3_frame_err", frame_err, 1);
    send_frame(16'hBEEF, 16'hCAFE);
    idle(3);
    check("s3_pairs", acc_cnt - a0, 1);
    check("s3_left", acc_l, 16'hBEEF);
    check("s3_right", acc_r, 16'hCAFE);

    // ws toggling every edge
    do_reset();
    rdy_req = 1'b1;
    send_frame(16'h0000, 16'h0000);
    a0 = acc_cnt;
    for (int i = 0; i < 6; i++) send_bit(i[0] ? 1'b0 : 1'b1, 1'b1);
    idle(3);
    check("s3b_frame_err", frame_err, 1);
    check("s3b_pairs", acc_cnt - a0, 0);
    check("s3b_valid", out_valid, 0);

    // Ready only on the completion edge of the next pair
    do_reset();
    send_frame(16'h0000, 16'h0000);
    send_frame(16'h1357, 16'h2468);
    a0 = acc_cnt;
    send_slot(1'b0, 32'h9ABC, W);
    for (int i = W - 1; i >= 1; i--) send_bit(1'b1, (i == 4) || (i >= 12));
    rdy_req = 1'b1;
    send_bit(1'b0, 1'b0);
    rdy_req = 1'b0;
    idle(2);
    check("s4_valid", out_valid, 1);
    check("s4_left", out_left, 16'h9ABC);
    check("s4_right", out_right, 16'hF010);
    check("s4_overrun", overrun, 0);
    check("s4_acc_left", acc_l, 16'h1357);
    check("s4_pairs", acc_cnt - a0, 1);

    // Asynchronous reset in the middle of a right slot
    do_reset();
    send_frame(16'h0000, 16'h0000);
    send_frame(16'h0F0F, 16'hF0F0);
    send_slot(1'b0, 32'h1111, W);
    for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b1);
    #3 rst = 1'b0;
    rst_req = 1'b0;
    model_reset();
    #1;
    check("s5_left_zero", out_left, 0);
    check("s5_right_zero", out_right, 0);
    check("s5_valid_zero", out_valid, 0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1);
    rst_req = 1'b1;
    rdy_req = 1'b1;
    a0 = acc_cnt;
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    check("s5_no_early_pair", acc_cnt - a0, 0);
    send_frame(16'hAAAA, 16'h5555);
    idle(3);
    check("s5_pairs", acc_cnt - a0, 1);
    check("s5_left", acc_l, 16'hAAAA);
    check("s5_right", acc_r, 16'h5555);

    // MSB/LSB alignment
    do_reset();
    send_frame(16'h0000, 16'h0000);
    send_frame(16'h8000, 16'h0001);
    idle(2);
    check("s6_left", out_left, 16'h8000);
    check("s6_right", out_right, 16'h0001);
    check("s6_valid", out_valid, 1);

    // Randomized traffic
    do_reset();
    rnd_rdy = 1'b1;
    for (int f = 0; f < 150; f++) begin
      sel = $urandom_range(0, 19);
      if (sel == 0) begin
        send_slot(1'b0, $urandom, ($urandom_range(0, 1) != 0) ? W - 1 : W + 1);
        send_slot(1'b1, $urandom, W);
      end else if (sel == 1) begin
        send_slot(1'b0, $urandom, W);
        send_slot(1'b1, $urandom, ($urandom_range(0, 1) != 0) ? W - 1 : W + 1);
      end else if (sel == 2) begin
        for (int i = 0; i < 3; i++) send_bit(~ws, 1'($urandom_range(0, 1)));
      end else if (sel == 3) begin
        do_reset();
      end else begin
        send_frame(W'($urandom), W'($urandom));
      end
    end
    rnd_rdy = 1'b0;
    rdy_req = 1'b1;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
